// File: rtl/i2c_peripheral.sv
// ---------------------------------------------------------------------------
// i2c_peripheral
// I2C target with a 7-bit address. It accepts a register-pointer byte and
// then data bytes on a write; on a read it returns the tx byte, reloading it
// for every byte the controller ACKs. It answers only to ADDR.
//
// Ports
//   clk    in     system clock, at least 8x the SCL rate
//   reset  in     synchronous active-high reset
//   scl    in     I2C clock from the controller (asynchronous)
//   sda    inout  I2C data, open drain: driven 0 or released, never 1
//   tx     in     byte returned on a read, sampled at the start of each byte
//   rx     out    last data byte written by the controller
//   rw     out    R/W bit of the most recent matching address byte
//
// Build option
//   I2C_PERIPHERAL_GLITCH_FILTER_EN : when defined, the synchronized scl and
//   sda each pass a 3-sample majority filter before edge detection. This adds
//   2 clk of latency and rejects pulses of 1 clk or less.
// ---------------------------------------------------------------------------
module i2c_peripheral #(
    parameter logic [6:0] ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx,
    output logic [7:0] rx,
    output logic       rw
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_REG       = 4'd3,
        ST_REG_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_WAIT      = 4'd9
    } state_t;

    logic       r_scl_meta, r_scl_sync, r_sda_meta, r_sda_sync;
    logic       r_scl_prev, r_sda_prev;
    logic       w_scl, w_sda;
    logic       w_scl_rise, w_scl_fall, w_start, w_stop;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic [3:0] r_bitcnt, w_bitcnt_nxt;
    logic [7:0] r_regptr, w_regptr_nxt;
    logic [7:0] r_txsh, w_txsh_nxt;
    logic       r_sda_low, w_sda_low_nxt;
    logic [7:0] r_rx, w_rx_nxt;
    logic       r_rw, w_rw_nxt;

    // Two-flop synchronizers; preset high so reset looks like an idle bus
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
        end else begin
            r_scl_meta <= scl;
            r_scl_sync <= r_scl_meta;
            r_sda_meta <= sda;
            r_sda_sync <= r_sda_meta;
        end
    end

`ifdef I2C_PERIPHERAL_GLITCH_FILTER_EN
    logic [2:0] r_scl_hist, r_sda_hist;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    // Three-sample history for the majority filters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scl_hist <= 3'b111;
            r_sda_hist <= 3'b111;
        end else begin
            r_scl_hist <= {r_scl_hist[1:0], r_scl_sync};
            r_sda_hist <= {r_sda_hist[1:0], r_sda_sync};
        end
    end

    assign w_scl = maj3(r_scl_hist);
    assign w_sda = maj3(r_sda_hist);
`else
    assign w_scl = r_scl_sync;
    assign w_sda = r_sda_sync;
`endif

    // Previous bus levels for edge and START/STOP detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    assign w_scl_rise = w_scl & ~r_scl_prev;
    assign w_scl_fall = ~w_scl & r_scl_prev;
    // START/STOP need scl high on both samples so an scl edge cannot alias
    assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
    assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

    // Open drain: only ever pull low; the pull-up supplies the 1
    assign sda = r_sda_low ? 1'b0 : 1'bz;
    assign rx  = r_rx;
    assign rw  = r_rw;

    // FSM state and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_shift   <= 8'h00;
            r_bitcnt  <= 4'd0;
            r_regptr  <= 8'h00;
            r_txsh    <= 8'h00;
            r_sda_low <= 1'b0;
            r_rx      <= 8'h00;
            r_rw      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_regptr  <= w_regptr_nxt;
            r_txsh    <= w_txsh_nxt;
            r_sda_low <= w_sda_low_nxt;
            r_rx      <= w_rx_nxt;
            r_rw      <= w_rw_nxt;
        end
    end

    // Next-state and datapath decode; sda changes only on an scl fall
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bitcnt_nxt  = r_bitcnt;
        w_regptr_nxt  = r_regptr;
        w_txsh_nxt    = r_txsh;
        w_sda_low_nxt = r_sda_low;
        w_rx_nxt      = r_rx;
        w_rw_nxt      = r_rw;

        if (w_stop) begin
            w_state_nxt   = ST_IDLE;
            w_sda_low_nxt = 1'b0;
            w_bitcnt_nxt  = 4'd0;
        end else if (w_start) begin
            // Covers repeated START too; the register pointer is kept
            w_state_nxt   = ST_ADDR;
            w_sda_low_nxt = 1'b0;
            w_bitcnt_nxt  = 4'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_WAIT: begin
                    w_sda_low_nxt = 1'b0;
                end
                ST_ADDR, ST_REG, ST_WDATA: begin
                    if (w_scl_rise && (r_bitcnt != 4'd8)) begin
                        w_shift_nxt  = {r_shift[6:0], w_sda};
                        w_bitcnt_nxt = r_bitcnt + 4'd1;
                        // rx follows the 8th data bit's rising edge
                        if ((r_state == ST_WDATA) && (r_bitcnt == 4'd7)) begin
                            w_rx_nxt = {r_shift[6:0], w_sda};
                        end else begin
                            w_rx_nxt = r_rx;
                        end
                    end else if (w_scl_fall && (r_bitcnt == 4'd8)) begin
                        w_bitcnt_nxt = 4'd0;
                        case (r_state)
                            ST_ADDR: begin
                                if (r_shift[7:1] == ADDR) begin
                                    w_state_nxt   = ST_ADDR_ACK;
                                    w_sda_low_nxt = 1'b1;
                                    w_rw_nxt      = r_shift[0];
                                end else begin
                                    w_state_nxt   = ST_WAIT;
                                end
                            end
                            ST_REG: begin
                                w_regptr_nxt  = r_shift;
                                w_state_nxt   = ST_REG_ACK;
                                w_sda_low_nxt = 1'b1;
                            end
                            default: begin
                                w_state_nxt   = ST_WDATA_ACK;
                                w_sda_low_nxt = 1'b1;
                            end
                        endcase
                    end else begin
                        w_bitcnt_nxt = r_bitcnt;
                    end
                end
                ST_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_bitcnt_nxt = 4'd0;
                        if (r_rw) begin
                            // First data bit goes out on the fall ending the ACK
                            w_state_nxt   = ST_RDATA;
                            w_sda_low_nxt = ~tx[7];
                            w_txsh_nxt    = {tx[6:0], 1'b0};
                        end else begin
                            w_state_nxt   = ST_REG;
                            w_sda_low_nxt = 1'b0;
                        end
                    end else begin
                        w_sda_low_nxt = 1'b1;
                    end
                end
                ST_REG_ACK, ST_WDATA_ACK: begin
                    if (w_scl_fall) begin
                        w_state_nxt   = ST_WDATA;
                        w_sda_low_nxt = 1'b0;
                        w_bitcnt_nxt  = 4'd0;
                    end else begin
                        w_sda_low_nxt = 1'b1;
                    end
                end
                ST_RDATA: begin
                    if (w_scl_rise) begin
                        w_bitcnt_nxt = r_bitcnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_bitcnt == 4'd8) begin
                            w_state_nxt   = ST_RDATA_ACK;
                            w_sda_low_nxt = 1'b0;
                            w_bitcnt_nxt  = 4'd0;
                        end else begin
                            w_sda_low_nxt = ~r_txsh[7];
                            w_txsh_nxt    = {r_txsh[6:0], 1'b0};
                        end
                    end else begin
                        w_bitcnt_nxt = r_bitcnt;
                    end
                end
                ST_RDATA_ACK: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = {r_shift[6:0], w_sda};
                    end else if (w_scl_fall) begin
                        w_bitcnt_nxt = 4'd0;
                        if (!r_shift[0]) begin
                            w_state_nxt   = ST_RDATA;
                            w_sda_low_nxt = ~tx[7];
                            w_txsh_nxt    = {tx[6:0], 1'b0};
                        end else begin
                            w_state_nxt   = ST_WAIT;
                            w_sda_low_nxt = 1'b0;
                        end
                    end else begin
                        w_sda_low_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt   = ST_IDLE;
                    w_sda_low_nxt = 1'b0;
                    w_bitcnt_nxt  = 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_peripheral.sv
// ---------------------------------------------------------------------------
// tb_i2c_peripheral
// Directed bench for i2c_peripheral: a behavioural I2C controller drives scl
// and an open-drain sda. Every check compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_i2c_peripheral;

    localparam int Q = 6;  // quarter SCL period in clk cycles

    logic       clk;
    logic       reset;
    logic       scl;
    logic       m_low;
    logic [7:0] tx;
    wire  [7:0] rx;
    wire        rw;
    wire        sda;

    int         n_err   = 0;
    int         n_chk   = 0;
    int         mon_cnt = 0;
    logic [7:0] rx_mid;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_peripheral #(.ADDR(7'h42)) dut (
        .clk   (clk),
        .reset (reset),
        .scl   (scl),
        .sda   (sda),
        .tx    (tx),
        .rx    (rx),
        .rw    (rw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts cycles where the bench has released sda but the line is low
    always @(negedge clk) begin
        if (!m_low && (sda === 1'b0)) mon_cnt <= mon_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_c();
        m_low = 1'b1; wq(Q); scl = 1'b0; wq(Q);
    endtask

    task automatic rstart_c();
        m_low = 1'b0; wq(Q); scl = 1'b1; wq(Q); m_low = 1'b1; wq(Q); scl = 1'b0; wq(Q);
    endtask

    task automatic stop_c();
        m_low = 1'b1; wq(Q); scl = 1'b1; wq(Q); m_low = 1'b0; wq(Q);
    endtask

    task automatic bit_write(input logic b);
        m_low = ~b; wq(Q); scl = 1'b1; wq(2 * Q); scl = 1'b0; wq(Q);
    endtask

    task automatic get_ack(output logic ack);
        m_low = 1'b0; wq(Q); scl = 1'b1; wq(Q);
        ack = (sda === 1'b0);
        wq(Q); scl = 1'b0; wq(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) bit_write(d[i]);
        rx_mid = rx;
        get_ack(ack);
    endtask

    task automatic read_byte(input logic ctrl_ack, input logic [7:0] next_tx, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            m_low = 1'b0; wq(Q); scl = 1'b1; wq(Q);
            d[i] = (sda !== 1'b0);
            wq(Q); scl = 1'b0; wq(Q);
        end
        tx = next_tx;
        m_low = ctrl_ack; wq(Q); scl = 1'b1; wq(2 * Q); scl = 1'b0; wq(Q);
    endtask

    initial begin
        logic       a1, a2, a3, ag;
        logic [7:0] d1, d2;
        int         m0;

        reset = 1'b1; scl = 1'b1; m_low = 1'b0; tx = 8'h00;
        wq(4);
        check("rst_rx", rx, 8'h00);
        check("rst_rw", {7'd0, rw}, 8'h00);
        check("rst_sda", {7'd0, sda}, 8'h01);
        check("rst_state", 8'(dut.r_state), 8'd0);
        reset = 1'b0;
        wq(4);

        // Write: 0x84, reg 0x67, data 0x66
        start_c();
        send_byte(8'h84, a1);
        send_byte(8'h67, a2);
        send_byte(8'h66, a3);
        check("wr_acks", {5'd0, a1, a2, a3}, 8'h07);
        check("wr_rx_bit8", rx_mid, 8'h66);
        check("wr_rx", rx, 8'h66);
        check("wr_rw", {7'd0, rw}, 8'h00);
        stop_c();
        check("wr_idle", 8'(dut.r_state), 8'd0);

        // Pointer write, repeated START, read with NACK
        start_c();
        send_byte(8'h84, a1);
        send_byte(8'h67, a2);
        rstart_c();
        tx = 8'h66;
        send_byte(8'h85, a3);
        read_byte(1'b0, 8'h66, d1);
        check("rd_acks", {5'd0, a1, a2, a3}, 8'h07);
        check("rd_data", d1, 8'h66);
        check("rd_rw", {7'd0, rw}, 8'h01);
        check("rd_rx", rx, 8'h66);
        check("rd_regptr", dut.r_regptr, 8'h67);
        stop_c();

        // Wrong address: nothing driven, WAIT until STOP
        m0 = mon_cnt;
        start_c();
        send_byte(8'h86, a1);
        send_byte(8'h11, a2);
        send_byte(8'h22, a3);
        check("na_acks", {5'd0, a1, a2, a3}, 8'h00);
        check("na_wait", 8'(dut.r_state), 8'd9);
        check("na_lowcnt", 8'(mon_cnt - m0), 8'd0);
        check("na_rx", rx, 8'h66);
        check("na_rw", {7'd0, rw}, 8'h01);
        stop_c();
        check("na_idle", 8'(dut.r_state), 8'd0);

        // Multi-byte read, tx changes between bytes
        tx = 8'hA5;
        start_c();
        send_byte(8'h85, a1);
        read_byte(1'b1, 8'h3C, d1);
        read_byte(1'b0, 8'h3C, d2);
        check("mr_ack", {7'd0, a1}, 8'h01);
        check("mr_byte1", d1, 8'hA5);
        check("mr_byte2", d2, 8'h3C);
        check("mr_wait", 8'(dut.r_state), 8'd9);
        stop_c();

        // Reset during WDATA bit 4 (bits 1,0,0,1 so sda is high at reset)
        start_c();
        send_byte(8'h84, a1);
        send_byte(8'h10, a2);
        bit_write(1'b1);
        bit_write(1'b0);
        bit_write(1'b0);
        m_low = 1'b0; wq(Q); scl = 1'b1; wq(Q);
        reset = 1'b1; wq(2);
        check("rs_sda", {7'd0, sda}, 8'h01);
        check("rs_rx", rx, 8'h00);
        check("rs_rw", {7'd0, rw}, 8'h00);
        check("rs_state", 8'(dut.r_state), 8'd0);
        reset = 1'b0; wq(Q - 2); scl = 1'b0; wq(Q);
        bit_write(1'b0);
        bit_write(1'b1);
        bit_write(1'b0);
        bit_write(1'b1);
        get_ack(ag);
        check("rs_ignored", {7'd0, ag}, 8'h00);
        stop_c();
        start_c();
        send_byte(8'h84, a1);
        send_byte(8'h05, a2);
        send_byte(8'h5A, a3);
        check("rs_wr_acks", {5'd0, a1, a2, a3}, 8'h07);
        check("rs_wr_rx", rx, 8'h5A);
        stop_c();
        check("rs_wr_idle", 8'(dut.r_state), 8'd0);

        // 1-clk low glitch on scl inside the first address bit
        start_c();
        m_low = 1'b0; wq(Q); scl = 1'b1; wq(Q);
        scl = 1'b0; wq(1); scl = 1'b1; wq(Q - 1);
        scl = 1'b0; wq(Q);
        for (int i = 6; i >= 0; i--) begin
            logic [7:0] addr_byte;
            addr_byte = 8'h84;
            bit_write(addr_byte[i]);
        end
        get_ack(ag);
`ifdef I2C_PERIPHERAL_GLITCH_FILTER_EN
        check("gl_ack", {7'd0, ag}, 8'h01);
`else
        check("gl_ack", {7'd0, ag}, 8'h00);
`endif
        stop_c();
        check("gl_idle", 8'(dut.r_state), 8'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/i2c_peripheral.md
I2C_PERIPHERAL -- requirements
Module: i2c_peripheral

Interface
REQ-001 Parameter: ADDR, default 7'h42, 7-bit target address this peripheral answers to.
REQ-002 clk  input  1  system clock; all logic is synchronous to its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 scl  input  1  I2C clock from the controller; asynchronous to clk.
REQ-005 sda  inout  1  I2C data; open-drain: the block drives only 0 or high-Z, never 1.
REQ-006 tx  input  8  byte returned to the controller during a read; sampled per byte.
REQ-007 rx  output  8  last data byte written by the controller, i.e. the byte after the register byte.
REQ-008 rw  output  1  R/W bit of the most recent matching address byte (1 = read).

Function
REQ-009 scl and sda SHALL pass through 2-flop synchronizers; edges are detected on the synchronized copies. clk SHALL be at least 8x the SCL rate.
REQ-010 START condition: sda falls while scl is high. STOP condition: sda rises while scl is high. Both SHALL be honoured in every state, including a repeated START mid-transfer.
REQ-011 Bit order SHALL be MSB first. Data bits are sampled on scl rising edges; sda is driven or released only while scl is low, on the synchronized scl falling edge.
REQ-012 States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT.
REQ-013 IDLE: START goes to ADDR. A STOP from any state goes to IDLE and releases sda.
REQ-014 ADDR: the block shifts 8 bits (7 address bits plus R/W).
  - Match with ADDR: go to ADDR_ACK, drive sda=0 for the 9th clock, latch rw.
  - Mismatch: go to WAIT, leave sda released and rw unchanged.
REQ-015 After ADDR_ACK:
  - rw=0 goes to REG.
  - rw=1 goes to RDATA and loads a shift register from tx on the scl falling edge that ends the ACK bit.
REQ-016 REG: receive 8 bits into an internal register pointer, then ACK (REG_ACK) and go to WDATA.
REQ-017 WDATA: receive 8 bits, then ACK (WDATA_ACK).
  - rx SHALL update with the byte on the 8th-bit scl rising edge.
  - Further bytes repeat WDATA, each overwriting rx.
REQ-018 RDATA: shift the tx byte out MSB first.
  - A 0 bit pulls sda low; a 1 bit releases sda.
  - sda is released for the 9th bit (RDATA_ACK), where the controller's bit is sampled.
REQ-019 RDATA_ACK outcomes:
  - Controller ACK (sda=0): reload tx and continue in RDATA.
  - NACK (sda=1): go to WAIT with sda released.
REQ-020 Repeated START after REG_ACK SHALL go to ADDR and keep the register pointer; this is the write-pointer-then-read sequence.
REQ-021 WAIT: ignore bits until START (goes to ADDR) or STOP (goes to IDLE).
REQ-022 The block SHALL never drive sda low while scl is high, except inside an ACK bit or a data bit it is already holding.

Reset
REQ-023 On reset:
  - state=IDLE, sda released, rx=8'h00, rw=0.
  - Shift registers, bit counter and register pointer cleared.
  - Synchronizers preset to 1 (bus idle).
REQ-024 Reset asserted mid-transfer SHALL release sda within one clk and ignore the bus until the next START.

Configuration
REQ-025 Macro I2C_PERIPHERAL_GLITCH_FILTER_EN controls input filtering.
  - Defined: synchronized scl and sda SHALL each pass a 3-sample majority filter before edge detection, adding 2 clk of latency; pulses of 1 clk or less are rejected.
  - Undefined: no filter; edges come directly from the synchronizers.

Verification
REQ-026 Write: START, 0x84 (0x42+W), 0x67, 0x66, STOP.
  - Required: ACK on all 3 bytes; rx=8'h66 after the 8th data bit; rw=0; state IDLE after STOP.
REQ-027 Read: START, 0x84, 0x67, repeated START, 0x85 with tx=8'h66; controller NACKs the data byte, then STOP.
  - Required: ACK on the 3 controller-sent bytes; sda carries 0,1,1,0,0,1,1,0; rw=1; rx unchanged.
REQ-028 Wrong address: START, 0x86, then 2 bytes.
  - Required: sda never driven low; rx and rw unchanged; WAIT until STOP.
REQ-029 Multi-byte read: controller ACKs the 1st byte; tx changes from 8'hA5 to 8'h3C between bytes.
  - Required: second byte out is 0x3C; NACK on the second byte goes to WAIT.
REQ-030 Reset: assert reset during the WDATA bit 4.
  - Required: sda released, rx=0, rw=0; the next full write completes normally.
REQ-031 With I2C_PERIPHERAL_GLITCH_FILTER_EN defined: inject a 1-clk low glitch on scl during the address byte.
  - Required: the glitch is ignored and the transfer still ACKs. Without the macro the same glitch corrupts the address.
